// File: rtl/int_ctrl.sv
// int_ctrl - memory-mapped interrupt controller.
//
// Latches edge- or level-type interrupt requests from the peripheral lines,
// masks them, picks a winner by fixed priority (bit 0 highest) and raises a
// single request to the CPU. The handler claims the winning ID by reading
// CLAIM and later completes it by writing the same ID back to CLAIM.
//
// Register map (word offset addr_i):
//   0 PENDING  read: pending bits; write: 1 clears an edge-type bit
//   1 MASK     read/write, 1 = enabled
//   2 MODE     read/write, 1 = edge, 0 = level
//   3 CLAIM    read: claim (side effect only in REQ); write: complete
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous reset, active low
//   src_i    raw interrupt lines, bit 0 = highest priority
//   addr_i   word offset inside the block
//   we_i     write strobe, one cycle per write
//   re_i     read strobe, one cycle per read
//   wdata_i  write data
//   rdata_o  read data, combinational from addr_i and current registers
//   irq_o    interrupt request to the CPU
//   id_o     ID currently in service, 0 when none
module int_ctrl #(
  parameter int N_SRC    = 6,
  parameter bit EDGE_RST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_i,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o,
  output logic [4:0]       id_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t           r_state, w_stateNext;
  logic [N_SRC-1:0] r_pending, r_mask, r_mode, r_srcQ;
  logic [N_SRC-1:0] w_pendingNext, w_active, w_winOh, w_rise;
  logic [4:0]       r_curId, w_curIdNext, w_winId;
  logic             w_wrPend, w_wrMask, w_wrMode, w_wrClaim, w_rdClaim, w_claim;
  logic             w_unusedBits;

  assign w_wrPend  = we_i && (addr_i == 2'd0);
  assign w_wrMask  = we_i && (addr_i == 2'd1);
  assign w_wrMode  = we_i && (addr_i == 2'd2);
  assign w_wrClaim = we_i && (addr_i == 2'd3);
  assign w_rdClaim = re_i && (addr_i == 2'd3);
  assign w_rise    = src_i & ~r_srcQ;
  assign w_active  = r_pending & r_mask;

  // Upper write-data bits have no register behind them.
  assign w_unusedBits = ^wdata_i[31:N_SRC];

  // Fixed-priority arbiter: scanning from the top down lets the lowest
  // active index overwrite any higher one, so bit 0 wins.
  always_comb begin
    w_winId = '0;
    w_winOh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_winId    = 5'(i + 1);
        w_winOh    = '0;
        w_winOh[i] = 1'b1;
      end
    end
  end

  // Claim/complete FSM. A drop of win_id in REQ (mask change or W1C) takes
  // precedence over a claim in the same cycle, so ID 0 is never claimed.
  always_comb begin
    w_stateNext = r_state;
    w_curIdNext = r_curId;
    w_claim     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_winId != 5'd0) w_stateNext = REQ;
      end
      REQ: begin
        if (w_winId == 5'd0) begin
          w_stateNext = IDLE;
        end else if (w_rdClaim) begin
          w_stateNext = SERV;
          w_curIdNext = w_winId;
          w_claim     = 1'b1;
        end
      end
      SERV: begin
        if (w_wrClaim && (wdata_i[4:0] == r_curId)) begin
          w_stateNext = IDLE;
          w_curIdNext = 5'd0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Pending update. Clears (W1C, claim) are applied before the new edge is
  // ORed in, so a set in the same cycle as a clear wins. Level-type bits
  // simply follow the raw line and ignore both clears.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_wrPend) w_pendingNext = w_pendingNext & ~wdata_i[N_SRC-1:0];
    if (w_claim)  w_pendingNext = w_pendingNext & ~w_winOh;
    w_pendingNext = w_pendingNext | w_rise;
    w_pendingNext = (w_pendingNext & r_mode) | (src_i & ~r_mode);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_curId   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_mode    <= {N_SRC{EDGE_RST}};
      r_srcQ    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_curId   <= w_curIdNext;
      r_pending <= w_pendingNext;
      r_srcQ    <= src_i;
      if (w_wrMask) r_mask <= wdata_i[N_SRC-1:0];
      if (w_wrMode) r_mode <= wdata_i[N_SRC-1:0];
    end
  end

  // CLAIM reads report the candidate in REQ and the serviced ID in SERV;
  // the read itself never changes state outside REQ.
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      2'd0: rdata_o[N_SRC-1:0] = r_pending;
      2'd1: rdata_o[N_SRC-1:0] = r_mask;
      2'd2: rdata_o[N_SRC-1:0] = r_mode;
      default: begin
        if (r_state == REQ)       rdata_o[4:0] = w_winId;
        else if (r_state == SERV) rdata_o[4:0] = r_curId;
      end
    endcase
  end

  assign irq_o = (r_state == REQ);
  assign id_o  = r_curId;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl - self-checking bench for int_ctrl.
//
// Every stimulus cycle pushes the expected irq/id (and read data when a read
// is issued) into a scoreboard queue; a monitor on the falling edge pops one
// entry per cycle and compares it against the DUT. Expectations come from a
// behavioural model that tracks "requesting" and "ID in service" directly.
module tb_int_ctrl;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src;
  logic [1:0]  addr;
  logic        we, re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [4:0]  id;

  typedef struct {
    string       name;
    logic        doRead;
    logic [31:0] rdata;
    logic        hasConst;
    logic [31:0] constVal;
    logic        irq;
    logic [4:0]  id;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  logic [5:0] curSrc = 6'h0;

  // Reference model state: pending/mask/mode bits, previous line values,
  // whether a request is being presented, and the ID in service.
  logic [5:0] mPend = 6'h0, mMask = 6'h0, mMode = 6'h3F, mSrcQ = 6'h0;
  logic       mReq  = 1'b0;
  logic [4:0] mCur  = 5'd0;
  logic [5:0] mNp;
  logic [4:0] mW, mClaimed;

  always #5 clk = ~clk;

  int_ctrl #(.N_SRC(6), .EDGE_RST(1'b1)) dut (
    .clk(clk), .reset(reset), .src_i(src), .addr_i(addr), .we_i(we),
    .re_i(re), .wdata_i(wdata), .rdata_o(rdata), .irq_o(irq), .id_o(id)
  );

  function automatic logic [4:0] modelWin();
    for (int i = 0; i < N; i++)
      if (mPend[i] && mMask[i]) return 5'(i + 1);
    return 5'd0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {26'b0, mPend};
      2'd1:    return {26'b0, mMask};
      2'd2:    return {26'b0, mMode};
      default: return mReq ? {27'b0, modelWin()} : {27'b0, mCur};
    endcase
  endfunction

  // Model advance on every rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    if (!reset) begin
      mPend = 6'h0; mMask = 6'h0; mMode = 6'h3F; mSrcQ = 6'h0;
      mReq  = 1'b0; mCur  = 5'd0;
    end else begin
      mW = modelWin();
      mClaimed = 5'd0;
      if (mReq) begin
        if (mW == 5'd0) mReq = 1'b0;
        else if (re && addr == 2'd3) begin
          mReq = 1'b0; mCur = mW; mClaimed = mW;
        end
      end else if (mCur != 5'd0) begin
        if (we && addr == 2'd3 && wdata[4:0] == mCur) mCur = 5'd0;
      end else if (mW != 5'd0) begin
        mReq = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (!mMode[i]) mNp[i] = src[i];
        else begin
          mNp[i] = mPend[i];
          if (we && addr == 2'd0 && wdata[i]) mNp[i] = 1'b0;
          if (mClaimed == 5'(i + 1))           mNp[i] = 1'b0;
          if (src[i] && !mSrcQ[i])             mNp[i] = 1'b1;
        end
      end
      mPend = mNp;
      if (we && addr == 2'd1) mMask = wdata[5:0];
      if (we && addr == 2'd2) mMode = wdata[5:0];
      mSrcQ = src;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Monitor: one scoreboard entry per stimulus cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.name, "/irq"}, 32'(irq), 32'(e.irq));
      checkOutput({e.name, "/id"}, 32'(id), 32'(e.id));
      if (e.doRead)   checkOutput({e.name, "/rdata"}, rdata, e.rdata);
      if (e.hasConst) checkOutput({e.name, "/const"}, rdata, e.constVal);
    end
  end

  task automatic applyStimulus(input string name, input logic rstN, input logic [5:0] s,
                               input logic [1:0] a, input logic w, input logic r,
                               input logic [31:0] d, input logic hasC, input logic [31:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rstN; src = s; addr = a; we = w; re = r; wdata = d;
    e.name = name; e.doRead = r; e.rdata = modelRead(a);
    e.hasConst = hasC; e.constVal = c; e.irq = mReq; e.id = mCur;
    expQ.push_back(e);
  endtask

  task automatic idle(input string name);
    applyStimulus(name, 1'b1, curSrc, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wr(input string name, input logic [1:0] a, input logic [31:0] d);
    applyStimulus(name, 1'b1, curSrc, a, 1'b1, 1'b0, d, 1'b0, 32'd0);
  endtask

  task automatic rdConst(input string name, input logic [1:0] a, input logic [31:0] c);
    applyStimulus(name, 1'b1, curSrc, a, 1'b0, 1'b1, 32'd0, 1'b1, c);
  endtask

  initial begin
    int          op;
    logic [1:0]  a;
    logic [31:0] d;

    reset = 1'b0; src = 6'h3F; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 32'd0;

    // Reset held with all lines high: registers read reset values.
    applyStimulus("rst0", 1'b0, 6'h3F, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus("rst1", 1'b0, 6'h3F, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus("rstPend",  1'b0, 6'h3F, 2'd0, 1'b0, 1'b1, 32'd0, 1'b1, 32'h00);
    applyStimulus("rstMask",  1'b0, 6'h3F, 2'd1, 1'b0, 1'b1, 32'd0, 1'b1, 32'h00);
    applyStimulus("rstMode",  1'b0, 6'h3F, 2'd2, 1'b0, 1'b1, 32'd0, 1'b1, 32'h3F);
    applyStimulus("rstClaim", 1'b0, 6'h3F, 2'd3, 1'b0, 1'b1, 32'd0, 1'b1, 32'h00);
    curSrc = 6'h0;
    idle("rstRel0"); idle("rstRel1");

    // Single edge on source 1.
    wr("edgeMask", 2'd1, 32'h03);
    curSrc = 6'h02; idle("edgePulse");
    curSrc = 6'h00; idle("edgeWait");
    rdConst("edgeClaim", 2'd3, 32'd2);
    rdConst("edgePend", 2'd0, 32'h0);
    wr("edgeDone", 2'd3, 32'd2);
    idle("edgeIdle");

    // Two simultaneous edges: lower index first, then the other.
    wr("prioMask", 2'd1, 32'h3F);
    curSrc = 6'h14; idle("prioRise");
    idle("prioWait");
    rdConst("prioClaim3", 2'd3, 32'd3);
    idle("prioServ");
    wr("prioDone3", 2'd3, 32'd3);
    idle("prioArb");
    rdConst("prioClaim5", 2'd3, 32'd5);
    wr("prioDone5", 2'd3, 32'd5);
    curSrc = 6'h00; idle("prioIdle0"); idle("prioIdle1");

    // Level source 0 held high, then dropped before the next claim.
    wr("lvlMode", 2'd2, 32'h3E);
    wr("lvlMask", 2'd1, 32'h01);
    curSrc = 6'h01; idle("lvlRise");
    idle("lvlWait");
    rdConst("lvlClaim", 2'd3, 32'd1);
    wr("lvlDone", 2'd3, 32'd1);
    idle("lvlArb"); idle("lvlReq");
    curSrc = 6'h00; idle("lvlDrop0"); idle("lvlDrop1"); idle("lvlDrop2"); idle("lvlDrop3");
    wr("lvlModeBack", 2'd2, 32'h3F);

    // Wrong-ID complete is ignored.
    wr("bndMask", 2'd1, 32'h3F);
    curSrc = 6'h02; idle("bndPulse");
    curSrc = 6'h00; idle("bndWait");
    rdConst("bndClaim", 2'd3, 32'd2);
    wr("bndWrongId", 2'd3, 32'd5);
    idle("bndServ0");
    rdConst("bndServRd", 2'd3, 32'd2);
    wr("bndDone", 2'd3, 32'd2);
    idle("bndIdle");

    // W1C and a new edge on the same bit in one cycle: the set wins.
    wr("w1cMask", 2'd1, 32'h00);
    curSrc = 6'h08; idle("w1cPulse");
    curSrc = 6'h00; idle("w1cLow");
    applyStimulus("w1cRace", 1'b1, 6'h08, 2'd0, 1'b1, 1'b0, 32'h08, 1'b0, 32'd0);
    curSrc = 6'h00;
    rdConst("w1cKept", 2'd0, 32'h08);
    wr("w1cClear", 2'd0, 32'h08);
    rdConst("w1cGone", 2'd0, 32'h00);

    // Mask cleared while requesting.
    wr("moMask", 2'd1, 32'h3F);
    curSrc = 6'h01; idle("moPulse");
    curSrc = 6'h00; idle("moWait");
    wr("moClear", 2'd1, 32'h00);
    idle("moDrop0"); idle("moDrop1");
    wr("moW1c", 2'd0, 32'h3F);

    // Reset while an ID is in service.
    wr("rsMask", 2'd1, 32'h3F);
    curSrc = 6'h02; idle("rsPulse");
    curSrc = 6'h00; idle("rsWait");
    rdConst("rsClaim", 2'd3, 32'd2);
    idle("rsServ");
    applyStimulus("rsReset", 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle("rsAfter");
    rdConst("rsClaimZero", 2'd3, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 9);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) curSrc = curSrc ^ (6'($urandom) & 6'($urandom));
      if (a == 2'd3 && $urandom_range(0, 2) != 0)
        d[4:0] = (mCur == 5'd0) ? 5'($urandom_range(1, 6)) : mCur;
      if (a == 2'd1 && $urandom_range(0, 1) == 0) d[5:0] = 6'h3F;
      if ($urandom_range(0, 199) == 0)
        applyStimulus("rndReset", 1'b0, curSrc, a, 1'b0, 1'b0, d, 1'b0, 32'd0);
      else if (op <= 3)
        idle("rndIdle");
      else if (op <= 6)
        applyStimulus("rndRead", 1'b1, curSrc, a, 1'b0, 1'b1, d, 1'b0, 32'd0);
      else if (op <= 8)
        applyStimulus("rndWrite", 1'b1, curSrc, a, 1'b1, 1'b0, d, 1'b0, 32'd0);
      else
        applyStimulus("rndRdWr", 1'b1, curSrc, a, 1'b1, 1'b1, d, 1'b0, 32'd0);
    end

    idle("tail");
    repeat (3) @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
